// File: rtl/fp_pipe_issue_ctrl.sv
// Issue/collect control for a 3-stage FP unit: one op/cycle issue, RAW hazard block, shadow dest tracking.
// Latency issue->wb_valid is 3 cycles; wb_ready=0 with a result waiting freezes the unit and blocks issue.
module fp_pipe_issue_ctrl #(
  parameter int STAGES = 3,
  parameter int RD_W   = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [RD_W-1:0]   req_rd,
  input  logic              req_fp_wr,
  input  logic              req_int_wr,
  input  logic [RD_W-1:0]   req_rs1,
  input  logic [RD_W-1:0]   req_rs2,
  input  logic              req_src_fp,
  input  logic              flush,
  output logic              p_start,
  output logic              unit_en,
  output logic [2:0]        unit_clear,
  input  logic              p_result,
  input  logic [DATA_W-1:0] unit_sum,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [RD_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_fp_write,
  output logic              wb_int_write,
  output logic [1:0]        inflight_cnt,
  output logic              proto_err
);

  localparam int LAST = STAGES - 1;

  typedef struct packed {
    logic            vld;
    logic [RD_W-1:0] rd;
    logic            fp_wr;
    logic            int_wr;
  } shd_t;

  shd_t              shd_q [STAGES];
  shd_t              shd_d [STAGES];
  logic              proto_err_q;
  logic              proto_err_d;
  logic [STAGES-1:0] hit;
  logic              hazard;
  logic [1:0]        cnt;

  // Output stage holding a result nobody will take freezes the whole unit.
  assign unit_en    = ~(shd_q[LAST].vld & ~wb_ready) & ~rst;
  assign unit_clear = {3{flush | rst}};

  // No bypass: a source matching any live destination waits until it has retired.
  always_comb begin
    hit = '0;
    for (int i = 0; i < STAGES; i++) begin
      if (shd_q[i].vld && (shd_q[i].rd == req_rs1 || shd_q[i].rd == req_rs2)) begin
        hit[i] = req_src_fp ? shd_q[i].fp_wr
                            : (shd_q[i].int_wr && (shd_q[i].rd != '0));
      end
    end
  end

  assign hazard    = |hit;
  assign req_ready = unit_en & ~hazard & ~flush & ~rst;
  assign p_start   = req_valid & req_ready;

  assign wb_valid     = shd_q[LAST].vld & ~flush & ~rst;
  assign wb_rd        = shd_q[LAST].rd;
  assign wb_fp_write  = shd_q[LAST].fp_wr;
  assign wb_int_write = shd_q[LAST].int_wr;
  assign wb_data      = unit_sum;

  always_comb begin
    shd_d = shd_q;
    if (flush) begin
      for (int i = 0; i < STAGES; i++) begin
        shd_d[i] = '0;
      end
    end else if (unit_en) begin
      shd_d[0] = p_start ? shd_t'{vld: 1'b1, rd: req_rd, fp_wr: req_fp_wr, int_wr: req_int_wr}
                         : shd_t'('0);
      for (int i = 1; i < STAGES; i++) begin
        shd_d[i] = shd_q[i-1];
      end
    end
  end

  // Unit's output valid must track our stage-2 shadow whenever it is not being cleared.
  always_comb begin
    proto_err_d = proto_err_q | (~flush & (p_result ^ shd_q[LAST].vld));
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < STAGES; i++) begin
      cnt = cnt + 2'(shd_q[i].vld);
    end
  end

  assign inflight_cnt = cnt;
  assign proto_err    = proto_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        shd_q[i] <= '0;
      end
      proto_err_q <= 1'b0;
    end else begin
      shd_q       <= shd_d;
      proto_err_q <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_fp_pipe_issue_ctrl.sv
// Bench: directed test-plan sequences plus random traffic against a queue-based reference model.
module tb_fp_pipe_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [4:0]  req_rd, req_rs1, req_rs2;
  logic        req_fp_wr, req_int_wr, req_src_fp;
  logic        flush;
  logic        p_start, unit_en;
  logic [2:0]  unit_clear;
  logic        p_result;
  logic [31:0] unit_sum;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_fp_write, wb_int_write;
  logic [1:0]  inflight_cnt;
  logic        proto_err;

  logic [31:0] tok;
  logic        bad_res;
  logic        u_v [3] = '{1'b0, 1'b0, 1'b0};
  logic [31:0] u_d [3] = '{32'd0, 32'd0, 32'd0};

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [4:0]  rd;
    logic        fp;
    logic        iw;
    logic [31:0] d;
    int          pos;
  } op_t;

  op_t mq[$];
  logic perr_m;

  always #5 clk = ~clk;

  fp_pipe_issue_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rd(req_rd),
    .req_fp_wr(req_fp_wr), .req_int_wr(req_int_wr), .req_rs1(req_rs1),
    .req_rs2(req_rs2), .req_src_fp(req_src_fp), .flush(flush),
    .p_start(p_start), .unit_en(unit_en), .unit_clear(unit_clear),
    .p_result(p_result), .unit_sum(unit_sum),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_fp_write(wb_fp_write), .wb_int_write(wb_int_write),
    .inflight_cnt(inflight_cnt), .proto_err(proto_err)
  );

  // Simple model of the attached 3-stage unit; bad_res corrupts its output valid.
  always @(posedge clk) begin
    if (unit_en) begin
      u_v[0] <= p_start; u_d[0] <= tok;
      u_v[1] <= u_v[0];  u_d[1] <= u_d[0];
      u_v[2] <= u_v[1];  u_d[2] <= u_d[1];
    end
    for (int i = 0; i < 3; i++) if (unit_clear[i]) u_v[i] <= 1'b0;
  end
  assign p_result = u_v[2] ^ bad_res;
  assign unit_sum = u_d[2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One cycle: drive inputs, check combinational and state outputs, advance the model.
  task automatic step(input logic v, input logic [4:0] rd, input logic fp, input logic iw,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic sfp,
                      input logic fl, input logic wr);
    logic s2, haz, en_e, rdy_e, st_e;
    req_valid = v; req_rd = rd; req_fp_wr = fp; req_int_wr = iw;
    req_rs1 = rs1; req_rs2 = rs2; req_src_fp = sfp; flush = fl; wb_ready = wr;
    tok = $urandom;
    @(negedge clk);
    s2  = (mq.size() > 0) && (mq[0].pos == 2);
    haz = 1'b0;
    foreach (mq[i]) begin
      if ((mq[i].rd == rs1 || mq[i].rd == rs2) &&
          (sfp ? mq[i].fp : (mq[i].iw && mq[i].rd != 5'd0)))
        haz = 1'b1;
    end
    en_e  = !(s2 && !wr);
    rdy_e = en_e && !haz && !fl;
    st_e  = v && rdy_e;
    chk("unit_en", unit_en, en_e);
    chk("req_ready", req_ready, rdy_e);
    chk("p_start", p_start, st_e);
    chk("unit_clear", unit_clear, fl ? 3'b111 : 3'b000);
    chk("wb_valid", wb_valid, s2 && !fl);
    if (s2 && !fl) begin
      chk("wb_rd", wb_rd, mq[0].rd);
      chk("wb_data", wb_data, mq[0].d);
      chk("wb_fp_write", wb_fp_write, mq[0].fp);
      chk("wb_int_write", wb_int_write, mq[0].iw);
    end
    chk("inflight_cnt", inflight_cnt, mq.size());
    chk("proto_err", proto_err, perr_m);
    if (bad_res && !fl) perr_m = 1'b1;
    if (fl) begin
      mq.delete();
    end else if (en_e) begin
      foreach (mq[i]) mq[i].pos++;
      if (mq.size() > 0 && mq[0].pos == 3) void'(mq.pop_front());
      if (st_e) mq.push_back('{rd: rd, fp: fp, iw: iw, d: tok, pos: 0});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 1'b0, 1'b0, 5'd30, 5'd30, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; bad_res = 1'b0; perr_m = 1'b0; tok = '0;
    req_valid = 1'b1; req_rd = 5'd1; req_fp_wr = 1'b1; req_int_wr = 1'b0;
    req_rs1 = 5'd0; req_rs2 = 5'd0; req_src_fp = 1'b0; flush = 1'b0; wb_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_p_start", p_start, 1'b0);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_unit_clear", unit_clear, 3'b111);
    chk("rst_unit_en", unit_en, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_inflight", inflight_cnt, 2'd0);
    chk("rst_proto_err", proto_err, 1'b0);

    // single issue rd=5 FP, result three cycles later
    step(1'b1, 5'd5, 1'b1, 1'b0, 5'd20, 5'd21, 1'b1, 1'b0, 1'b1);
    idle(4);
    // three back-to-back independent issues
    step(1'b1, 5'd1, 1'b1, 1'b0, 5'd20, 5'd21, 1'b1, 1'b0, 1'b1);
    step(1'b1, 5'd2, 1'b1, 1'b0, 5'd20, 5'd21, 1'b1, 1'b0, 1'b1);
    step(1'b1, 5'd3, 1'b1, 1'b0, 5'd20, 5'd21, 1'b1, 1'b0, 1'b1);
    idle(4);
    // RAW on FP rd=7: blocked three cycles, accepted on the fourth
    step(1'b1, 5'd7, 1'b1, 1'b0, 5'd20, 5'd21, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 5'd9, 1'b1, 1'b0, 5'd7, 5'd22, 1'b1, 1'b0, 1'b1);
    idle(4);
    // int rd=0 and int-only rd=4 in flight: neither blocks
    step(1'b1, 5'd0, 1'b0, 1'b1, 5'd20, 5'd21, 1'b0, 1'b0, 1'b1);
    step(1'b1, 5'd4, 1'b0, 1'b1, 5'd20, 5'd21, 1'b0, 1'b0, 1'b1);
    step(1'b1, 5'd10, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 5'd11, 1'b1, 1'b0, 5'd4, 5'd4, 1'b1, 1'b0, 1'b1);
    idle(4);
    // writeback back-pressure for 4 cycles with a result waiting
    step(1'b1, 5'd12, 1'b0, 1'b1, 5'd20, 5'd21, 1'b0, 1'b0, 1'b1);
    idle(2);
    for (int i = 0; i < 4; i++) step(1'b1, 5'd13, 1'b1, 1'b0, 5'd20, 5'd21, 1'b1, 1'b0, 1'b0);
    idle(4);
    // flush with three in flight and a result on offer
    step(1'b1, 5'd1, 1'b1, 1'b0, 5'd20, 5'd21, 1'b1, 1'b0, 1'b1);
    step(1'b1, 5'd2, 1'b1, 1'b0, 5'd20, 5'd21, 1'b1, 1'b0, 1'b1);
    step(1'b1, 5'd3, 1'b1, 1'b0, 5'd20, 5'd21, 1'b1, 1'b0, 1'b1);
    step(1'b1, 5'd6, 1'b1, 1'b0, 5'd20, 5'd21, 1'b1, 1'b1, 1'b1);
    idle(2);

    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom),
           $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0);
    end

    // corrupted p_result after a clean flush must latch proto_err
    step(1'b0, 5'd0, 1'b0, 1'b0, 5'd30, 5'd30, 1'b0, 1'b1, 1'b1);
    idle(1);
    bad_res = 1'b1;
    idle(1);
    bad_res = 1'b0;
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
